// File: rtl/c7b_csr_pkg.sv
// Shared CSR constants and address decode for the c7b timer/interrupt block.
package c7b_csr_pkg;

  localparam logic [13:0] CSR_ECFG  = 14'h004;
  localparam logic [13:0] CSR_ESTAT = 14'h005;
  localparam logic [13:0] CSR_TCFG  = 14'h041;
  localparam logic [13:0] CSR_TVAL  = 14'h042;
  localparam logic [13:0] CSR_TICLR = 14'h044;

  localparam int TCFG_EN       = 0;
  localparam int TCFG_PERIODIC = 1;
  localparam int ESTAT_TI      = 11;
  localparam int ECFG_LIE_TI   = 11;
  localparam int ECFG_W        = 13;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_ECFG,
    SEL_ESTAT,
    SEL_TCFG,
    SEL_TVAL,
    SEL_TICLR
  } csr_sel_e;

  // Map a raw CSR address onto the registers this block owns.
  function automatic csr_sel_e decode_csr(input logic [13:0] addr);
    csr_sel_e sel;
    case (addr)
      CSR_ECFG:  sel = SEL_ECFG;
      CSR_ESTAT: sel = SEL_ESTAT;
      CSR_TCFG:  sel = SEL_TCFG;
      CSR_TVAL:  sel = SEL_TVAL;
      CSR_TICLR: sel = SEL_TICLR;
      default:   sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/c7b_timer_counter.sv
// TVAL down-counter with running flag, periodic reload and expiry detect.
module c7b_timer_counter
  import c7b_csr_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               load_en,
  input  logic [TIMER_W-1:2] load_init,
  input  logic               periodic,
  input  logic [TIMER_W-1:2] init_val,
  output logic [TIMER_W-1:0] tval,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic running;

  // An expiry is a running cycle at zero, unless a TCFG write takes priority.
  assign expire = running && (tval == '0) && !load;

  // Load on TCFG write, otherwise reload/stop on expiry or count down.
  always_ff @(posedge clk) begin
    if (reset) begin
      tval    <= '0;
      running <= 1'b0;
    end else if (load) begin
      tval    <= {load_init, 2'b00};
      running <= load_en;
    end else if (expire) begin
      if (periodic) begin
        tval <= {init_val, 2'b00};
      end else begin
        running <= 1'b0;
      end
    end else if (running) begin
      tval <= tval - ONE;
    end
  end

endmodule

// File: rtl/c7b_timer_top.sv
// Constant-timer CSRs (TCFG/TVAL/TICLR), ESTAT.TI and ECFG.LIE for the c7b core.
module c7b_timer_top
  import c7b_csr_pkg::*;
#(
  parameter int TIMER_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic        global_ie,
  output logic        timer_int,
  output logic        int_req
);

  csr_sel_e           wsel;
  csr_sel_e           rsel;
  logic               tcfg_wr;
  logic               ecfg_wr;
  logic               ticlr_wr;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] tval;
  logic [ECFG_W-1:0]  ecfg;
  logic               ti;
  logic               expire;
  logic [31:0]        tcfg_ext;
  logic [31:0]        tval_ext;

  assign wsel     = decode_csr(csr_waddr);
  assign rsel     = decode_csr(csr_raddr);
  assign tcfg_wr  = csr_we && (wsel == SEL_TCFG);
  assign ecfg_wr  = csr_we && (wsel == SEL_ECFG);
  assign ticlr_wr = csr_we && (wsel == SEL_TICLR);

  c7b_timer_counter #(
    .TIMER_W (TIMER_W)
  ) u_counter (
    .clk       (clk),
    .reset     (reset),
    .load      (tcfg_wr),
    .load_en   (csr_wdata[TCFG_EN]),
    .load_init (csr_wdata[TIMER_W-1:2]),
    .periodic  (tcfg[TCFG_PERIODIC]),
    .init_val  (tcfg[TIMER_W-1:2]),
    .tval      (tval),
    .expire    (expire)
  );

  // TCFG and ECFG are plain storage written through the CSR port.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
      ecfg <= '0;
    end else begin
      if (tcfg_wr) tcfg <= csr_wdata[TIMER_W-1:0];
      if (ecfg_wr) ecfg <= csr_wdata[ECFG_W-1:0];
    end
  end

  // TI latches on expiry; a TICLR write with bit0 set clears it, but set wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      ti <= 1'b0;
    end else if (expire) begin
      ti <= 1'b1;
    end else if (ticlr_wr && csr_wdata[0]) begin
      ti <= 1'b0;
    end
  end

  // Zero-extend the timer-width registers onto the 32-bit read bus.
  always_comb begin
    tcfg_ext              = '0;
    tval_ext              = '0;
    tcfg_ext[TIMER_W-1:0] = tcfg;
    tval_ext[TIMER_W-1:0] = tval;
  end

  // Combinational read mux; unmapped addresses and TICLR read as zero.
  always_comb begin
    csr_rdata = '0;
    case (rsel)
      SEL_ECFG:  csr_rdata[ECFG_W-1:0] = ecfg;
      SEL_ESTAT: csr_rdata[ESTAT_TI]   = ti;
      SEL_TCFG:  csr_rdata             = tcfg_ext;
      SEL_TVAL:  csr_rdata             = tval_ext;
      default:   csr_rdata             = '0;
    endcase
  end

  assign timer_int = ti;
  assign int_req   = ti & ecfg[ECFG_LIE_TI] & global_ie;

endmodule

// File: tb/tb_c7b_timer_top.sv
// Bench for c7b_timer_top: directed timer scenarios followed by random CSR traffic.
module tb_c7b_timer_top;
  import c7b_csr_pkg::*;

  localparam int TIMER_W = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        global_ie;
  logic        timer_int;
  logic        int_req;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference state: configuration seen at the last TCFG write and edges since then.
  longint      m_v;
  longint      m_k;
  bit          m_en;
  bit          m_per;
  bit          m_ti;
  logic [12:0] m_lie;
  logic [31:0] m_tcfg;
  logic        gie;

  always #10 clk = ~clk;

  c7b_timer_top #(
    .TIMER_W (TIMER_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .csr_we    (csr_we),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .global_ie (global_ie),
    .timer_int (timer_int),
    .int_req   (int_req)
  );

  // Expected TVAL as a closed-form function of edges since the last TCFG write.
  function automatic longint mdl_tval();
    if (!m_en) return m_v;
    if (m_per) return m_v - (m_k % (m_v + 1));
    return (m_k >= m_v) ? 64'd0 : m_v - m_k;
  endfunction

  // The timer is running and sitting at zero in the current cycle.
  function automatic bit mdl_at_expiry();
    if (!m_en) return 1'b0;
    if (m_per) return (m_k % (m_v + 1)) == m_v;
    return m_k == m_v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic modelUpdate(input logic we, input logic [13:0] waddr,
                             input logic [31:0] wdata, input logic rst);
    bit tcfg_wr;
    bit expiry;
    if (rst) begin
      m_v = 0; m_k = 0; m_en = 0; m_per = 0; m_ti = 0; m_lie = '0; m_tcfg = '0;
    end else begin
      tcfg_wr = we && (waddr == CSR_TCFG);
      expiry  = mdl_at_expiry() && !tcfg_wr;
      if (expiry) m_ti = 1'b1;
      else if (we && waddr == CSR_TICLR && wdata[0]) m_ti = 1'b0;
      if (we && waddr == CSR_ECFG) m_lie = wdata[12:0];
      if (tcfg_wr) begin
        m_tcfg = wdata;
        m_v    = longint'(wdata & 32'hFFFF_FFFC);
        m_en   = wdata[0];
        m_per  = wdata[1];
        m_k    = 0;
      end else begin
        m_k++;
      end
    end
  endtask

  task automatic readCsr(input logic [13:0] addr, output logic [31:0] data);
    csr_raddr = addr;
    #1;
    data = csr_rdata;
  endtask

  task automatic checkOutput();
    logic [31:0] d;
    readCsr(CSR_ECFG, d);  chk("ecfg", d, {19'b0, m_lie});
    readCsr(CSR_ESTAT, d); chk("estat", d, {20'b0, m_ti, 11'b0});
    readCsr(CSR_TCFG, d);  chk("tcfg", d, m_tcfg);
    readCsr(CSR_TVAL, d);  chk("tval", d, 32'(mdl_tval()));
    readCsr(CSR_TICLR, d); chk("ticlr", d, 32'h0);
    readCsr(14'h006, d);   chk("unmapped", d, 32'h0);
    chk("timer_int", {31'b0, timer_int}, {31'b0, m_ti});
    chk("int_req", {31'b0, int_req}, {31'b0, m_ti & m_lie[11] & gie});
  endtask

  // One clock: drive inputs, advance the reference at the edge, check at negedge.
  task automatic applyStimulus(input logic we, input logic [13:0] waddr,
                               input logic [31:0] wdata, input logic rst);
    csr_we    = we;
    csr_waddr = waddr;
    csr_wdata = wdata;
    reset     = rst;
    global_ie = gie;
    @(posedge clk);
    modelUpdate(we, waddr, wdata, rst);
    @(negedge clk);
    csr_we = 1'b0;
    reset  = 1'b0;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 14'h0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] d;
    int          sets;
    int          last_set;
    bit          clear_pending;
    int          r;
    logic [31:0] wd;

    reset = 1'b1; csr_we = 1'b0; csr_waddr = '0; csr_wdata = '0; csr_raddr = '0;
    gie = 1'b0; global_ie = 1'b0;
    m_v = 0; m_k = 0; m_en = 0; m_per = 0; m_ti = 0; m_lie = '0; m_tcfg = '0;

    // Reset state
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1);
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1);
    readCsr(CSR_TCFG, d);  chk("reset_tcfg", d, 32'h0);
    readCsr(CSR_TVAL, d);  chk("reset_tval", d, 32'h0);
    readCsr(CSR_ESTAT, d); chk("reset_estat", d, 32'h0);

    // One-shot: TVAL 0x10 after the write, 0 sixteen edges later, TI one edge after that
    applyStimulus(1'b1, CSR_TCFG, 32'h11, 1'b0);
    readCsr(CSR_TVAL, d); chk("oneshot_load", d, 32'h10);
    idle(16);
    readCsr(CSR_TVAL, d); chk("oneshot_zero", d, 32'h0);
    chk("oneshot_ti_not_yet", {31'b0, timer_int}, 32'h0);
    idle(1);
    chk("oneshot_ti_set", {31'b0, timer_int}, 32'h1);
    idle(4);
    readCsr(CSR_TVAL, d); chk("oneshot_hold", d, 32'h0);
    applyStimulus(1'b1, CSR_TICLR, 32'h1, 1'b0);
    idle(5);
    chk("oneshot_no_reexpire", {31'b0, timer_int}, 32'h0);

    // Clear in the expiry cycle loses to the set; a TICLR of 0 does nothing
    applyStimulus(1'b1, CSR_TCFG, 32'h11, 1'b0);
    idle(16);
    applyStimulus(1'b1, CSR_TICLR, 32'h1, 1'b0);
    chk("collision_set_wins", {31'b0, timer_int}, 32'h1);
    applyStimulus(1'b1, CSR_TICLR, 32'h0, 1'b0);
    chk("ticlr_zero", {31'b0, timer_int}, 32'h1);

    // Interrupt gating by ECFG.LIE[11] and global_ie
    gie = 1'b0;
    applyStimulus(1'b1, CSR_ECFG, 32'h800, 1'b0);
    chk("gate_lie1_ie0", {31'b0, int_req}, 32'h0);
    gie = 1'b1;
    idle(1);
    chk("gate_lie1_ie1", {31'b0, int_req}, 32'h1);
    applyStimulus(1'b1, CSR_ECFG, 32'h0, 1'b0);
    chk("gate_lie0_ie1", {31'b0, int_req}, 32'h0);
    gie = 1'b0;
    applyStimulus(1'b1, CSR_ECFG, 32'hFFFF_FFFF, 1'b0);
    readCsr(CSR_ECFG, d); chk("ecfg_width", d, 32'h1FFF);
    chk("gate_lie1_ie0_b", {31'b0, int_req}, 32'h0);
    gie = 1'b1;
    idle(1);
    chk("gate_lie1_ie1_b", {31'b0, int_req}, 32'h1);

    // Stop with TCFG=0: counter parked, TI retained
    applyStimulus(1'b1, CSR_TCFG, 32'h0, 1'b0);
    idle(3);
    readCsr(CSR_TVAL, d); chk("stop_tval", d, 32'h0);
    chk("stop_ti_kept", {31'b0, timer_int}, 32'h1);
    applyStimulus(1'b1, CSR_TICLR, 32'h1, 1'b0);

    // Periodic: InitVal*4=8 gives TI every 9 edges; clear after each one
    applyStimulus(1'b1, CSR_TCFG, 32'h0B, 1'b0);
    sets = 0; last_set = 0; clear_pending = 1'b0;
    for (int i = 1; i <= 2000 && sets < 90; i++) begin
      if (clear_pending) applyStimulus(1'b1, CSR_TICLR, 32'h1, 1'b0);
      else idle(1);
      clear_pending = 1'b0;
      if (timer_int) begin
        sets++;
        if (sets == 1) chk("periodic_first", 32'(i), 32'd9);
        else chk("periodic_period", 32'(i - last_set), 32'd9);
        last_set = i;
        clear_pending = 1'b1;
      end
    end
    chk("periodic_count", 32'(sets), 32'h5a);
    applyStimulus(1'b1, CSR_TCFG, 32'h0, 1'b0);
    applyStimulus(1'b1, CSR_TICLR, 32'h1, 1'b0);

    // Mid-count TCFG rewrite; same-cycle read returns the old TVAL
    applyStimulus(1'b1, CSR_TCFG, 32'h41, 1'b0);
    idle(5);
    csr_we = 1'b1; csr_waddr = CSR_TCFG; csr_wdata = 32'h21;
    readCsr(CSR_TVAL, d); chk("prewrite_read", d, 32'h3b);
    applyStimulus(1'b1, CSR_TCFG, 32'h21, 1'b0);
    readCsr(CSR_TVAL, d); chk("rewrite_load", d, 32'h20);
    idle(1);
    readCsr(CSR_TVAL, d); chk("rewrite_count", d, 32'h1f);

    // Reset mid-count
    applyStimulus(1'b0, 14'h0, 32'h0, 1'b1);
    readCsr(CSR_TCFG, d);  chk("midreset_tcfg", d, 32'h0);
    readCsr(CSR_TVAL, d);  chk("midreset_tval", d, 32'h0);
    readCsr(CSR_ESTAT, d); chk("midreset_estat", d, 32'h0);

    // Random CSR traffic against the reference
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 15));
      case (r)
        0, 1: begin
          wd = ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
          applyStimulus(1'b1, CSR_TCFG, wd, 1'b0);
        end
        2, 3: applyStimulus(1'b1, CSR_TICLR, $urandom, 1'b0);
        4:    applyStimulus(1'b1, CSR_ECFG, $urandom, 1'b0);
        5: begin
          case ($urandom_range(0, 2))
            0:       applyStimulus(1'b1, CSR_ESTAT, $urandom, 1'b0);
            1:       applyStimulus(1'b1, CSR_TVAL, $urandom, 1'b0);
            default: applyStimulus(1'b1, 14'h123, $urandom, 1'b0);
          endcase
        end
        6: begin
          gie = ~gie;
          idle(1);
        end
        7: applyStimulus(1'b0, 14'h0, 32'h0, ($urandom_range(0, 7) == 0));
        default: idle(1);
      endcase
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/c7b_timer_top.md
Name: c7b_timer_top

Overview:
Constant-timer and timer-interrupt CSR block for the c7b core. Implements TCFG, TVAL, TICLR, the timer bit of ESTAT and ECFG.LIE. It is accessed through the core's CSR read/write port and drives the timer interrupt request into the core's interrupt logic. Supports one-shot and periodic modes.

Parameters:
TIMER_W, 32, width of the TVAL counter and the TCFG.InitVal field (bits [TIMER_W-1:2]); range 8..32.

Ports:
clk  in  1  core clock, rising edge.
reset  in  1  synchronous reset, active-high.
csr_raddr  in  14  CSR read address.
csr_rdata  out  32  combinational read data; 0 for unmapped addresses.
csr_we  in  1  CSR write strobe, applied at the clk edge.
csr_waddr  in  14  CSR write address.
csr_wdata  in  32  CSR write data.
global_ie  in  1  CRMD.IE from the core.
timer_int  out  1  ESTAT.IS[11] (TI) level.
int_req  out  1  TI & ECFG.LIE[11] & global_ie.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset values: TCFG=0, TVAL=0, running=0, TI=0, LIE=0, so timer_int=0 and int_req=0.
- CSR addresses:
  - ECFG 0x004: only bits[12:0] are stored; the other bits read 0.
  - ESTAT 0x005: bit11=TI; the other bits read 0; writes to it are ignored.
  - TCFG 0x041: bit0 En, bit1 Periodic, bits[TIMER_W-1:2] InitVal.
  - TVAL 0x042: read-only.
  - TICLR 0x044: reads 0.
- TCFG write:
  - TCFG takes csr_wdata[TIMER_W-1:0].
  - Next cycle TVAL = {wdata[TIMER_W-1:2],2'b00}.
  - running = wdata[0].
  - A TCFG write overrides any same-cycle decrement or reload.
- Count: each cycle with running=1 and TVAL!=0, TVAL decrements by 1.
- Expiry: a cycle with running=1 and TVAL==0 and no TCFG write.
  - TI is set to 1 on the next edge.
  - If Periodic=1, TVAL reloads {InitVal,2'b00} and running stays 1.
  - If Periodic=0, running goes to 0 and TVAL holds 0. TCFG.En is not modified.
- Period: in periodic mode TI is set every InitVal*4+1 cycles.
  - Example: TCFG write at edge N with InitVal*4=4 gives TVAL 4,3,2,1,0 over cycles N+1..N+5, and TI=1 from edge N+6.
  - InitVal=0 with Periodic=1 sets TI every cycle.
- TICLR write with wdata[0]=1 clears TI next edge. If an expiry occurs in the same cycle, set wins. Writing wdata[0]=0 has no effect.
- En=0 write: the timer stops; TI keeps its current value.
- Reads are combinational. A read of TVAL in the same cycle as a write returns the pre-write value.
- int_req is combinational from registered state and global_ie.
- Reset mid-count returns all state to reset values.

Decomposition:
- Shared package c7b_csr_pkg:
  - CSR address constants CSR_ECFG, CSR_ESTAT, CSR_TCFG, CSR_TVAL, CSR_TICLR.
  - Bit positions TCFG_EN=0, TCFG_PERIODIC=1, ESTAT_TI=11.
- One natural sub-module: c7b_timer_counter, holding the TVAL register, running flag, reload/decrement logic and expiry pulse.
- CSR decode, TI and ECFG live in the top.

Test Plan:
- Reset state: after reset, TCFG, TVAL and ESTAT all read 0; timer_int=0; int_req=0.
- One-shot timing: write TCFG=0x11 (InitVal*4=0x10, En=1, Periodic=0) at edge N.
  - TVAL reads 0x10 at N+1 and 0 at N+17.
  - timer_int rises at N+18.
  - TVAL stays 0 and no further expiry occurs.
- Periodic mode: write TCFG=0x0B (TVAL 8, En, Periodic).
  - TI is set at N+10; clear it via TICLR=1.
  - TI is set again exactly 9 cycles after the previous set.
  - Count 0x5a expiries with a clear after each. The total must be 0x5a and the period must stay 9 throughout.
- Clear/set collision: issue a TICLR=1 write in the expiry cycle -> TI remains 1.
  - TICLR write of 0 -> no change.
- Interrupt gating: with TI=1, toggle ECFG bit11 and global_ie; int_req=1 only when both are 1.
  - Stop the timer with a TCFG=0 write: TVAL freezes and TI is retained.
- Mid-count events:
  - Rewrite TCFG mid-count -> TVAL reloads the new value on the next cycle.
  - Assert reset mid-count -> all reads return 0 next cycle.
